fifo_pkt_sink: RTL and testbench
================================

# fifo_pkt_sink

Downstream packet sink for the CPU/FIFO test harness. It sits on the output interface of `convertable_fifo_controller` and takes over the role of the constant `out_rdy = 1` tie-off. It consumes the 64-bit data / 8-bit ctrl packet stream and applies programmable backpressure. It checks packet framing, then publishes counters, the last packet's byte length and a payload XOR signature for the bench and debug ports.

## Interface
Parameters:
- `DATA_WIDTH`, 64, data bus width (fixed at 64; length math requires it).
- `CTRL_WIDTH`, 8, ctrl bus width (DATA_WIDTH/8).
- `LFSR_SEED`, 16'hACE1, reset value of the backpressure LFSR (must be non-zero).

Ports:
- `clk`  in  1  single clock domain.
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  64  word from FIFO `out_data`.
- `in_ctrl`  in  8  ctrl from FIFO `out_ctrl`.
- `in_wr`  in  1  word valid, from FIFO `out_wr`.
- `in_rdy`  out  1  to FIFO `out_rdy`; registered.
- `bp_mode`  in  2  backpressure mode: 0 always ready, 1 alternate, 2 LFSR, 3 never ready.
- `clear`  in  1  zeroes counters and results; does not affect framing state.
- `pkt_count`  out  32  good packets completed.
- `word_count`  out  32  accepted words, including header words.
- `err_count`  out  16  framing/protocol errors; saturates at 16'hFFFF.
- `last_len`  out  16  byte length of the last good packet.
- `last_sig`  out  64  XOR of all payload words of the last good packet.
- `pkt_done`  out  1  one-cycle pulse when a good packet completes.

## Operation
- Accept: a word is accepted on an edge where `in_wr && in_rdy`.
- Overrun: `in_wr` while `in_rdy == 0` is an overrun. The word is dropped, `err_count` increments, and the state is unchanged.
- Ctrl classes:
  - HDR: 8'hFF.
  - DATA: 8'h00.
  - EOP: one-hot, where bit 7 means 1 valid byte and bit 0 means 8 valid bytes.
  - Anything else is ILLEGAL.
- FSM states and transitions:
  - IDLE:
    - HDR → HDR state.
    - Any other accepted class → error, stay in IDLE.
  - HDR:
    - HDR → stay.
    - DATA → PAYLOAD; `words` = 1, `sig` = data.
    - EOP or ILLEGAL → error, go to IDLE.
  - PAYLOAD:
    - DATA → `words`++, `sig` ^= data.
    - EOP → complete the packet, go to IDLE.
    - HDR or ILLEGAL → error, go to IDLE (packet discarded).
- Completion:
  - `last_len` = 8·`words` + k, where k = 8 − (index of the set bit in ctrl).
  - `last_sig` = `sig` ^ data, with EOP data masked to its valid bytes (MSB bytes first).
  - `pkt_count`++ and `pkt_done` pulses.
- Every accepted word increments `word_count`, including words that cause errors.
- `words` is 13 bits and saturates. Packets of 8191 or more words complete with length clamped to 16'hFFFF.
- Simultaneous events:
  - `clear` with a completion: `clear` wins for counters. `last_*` and `pkt_done` still take the new packet's values.
  - `clear` with an error: `err_count` becomes 0.
- Backpressure (next-cycle `in_rdy`):
  - Mode 0: 1.
  - Mode 1: toggles every cycle, starting at 1 after reset.
  - Mode 2: LFSR bit 0. The 16-bit Fibonacci LFSR uses taps 16,14,13,11 and advances every cycle.
  - Mode 3: 0.
  - A mode change takes effect on the next edge.

## Timing
- Reset values: `in_rdy`=0, all counters 0, `last_len`=0, `last_sig`=0, `pkt_done`=0, FSM=IDLE, LFSR=`LFSR_SEED`.
- `in_rdy` rises on the first edge after `reset` deasserts (modes 0–2).
- The count, `last_len`, `last_sig` and `pkt_done` updates are visible one edge after the accepting edge.
- No combinational path from `in_wr`, `in_data` or `in_ctrl` to any output.
- Reset mid-packet: the partial packet is discarded silently and no error is counted.

## Structure
- Shared package holds the ctrl constants CTRL_HDR=8'hFF and CTRL_DATA=8'h00, the state encoding {IDLE, HDR, PAYLOAD}, and the bp_mode encodings.
- One sub-module: `bp_lfsr16`, with `clk`, `reset`, seed parameter and 16-bit state output.

## Test plan
- Mode 0; send HDR, then DATA 64'h1111…, then EOP ctrl 8'h01 with data 64'h2222… → `pkt_count`=1, `last_len`=16, `last_sig`=64'h3333…, `word_count`=3, one `pkt_done` pulse.
- Mode 0; send HDR, DATA, EOP ctrl 8'h80 with data 64'hAB00_…_FF → `last_len`=9. The masked EOP word is 64'hAB00_0000_0000_0000.
- DATA in IDLE, EOP directly after HDR, and ctrl 8'h03 mid-payload → `err_count`=3, `pkt_count`=0, FSM back in IDLE after each.
- Mode 3; pulse `in_wr` twice → `err_count`=2, `word_count`=0, `in_rdy` held at 0.
- Mode 1 and mode 2; drive a producer that respects `in_rdy` with 100 packets → `pkt_count`=100, `err_count`=0, signatures match the model.
- Assert `reset` mid-payload, then send a good packet → `err_count`=0, `pkt_count`=1. Assert `clear` coincident with EOP → counters 0, `last_len` updated.

Source files
------------

// File: rtl/fifo_pkt_sink_pkg.sv
// fifo_pkt_sink_pkg: ctrl constants, state/mode/class encodings and ctrl decode helpers
package fifo_pkt_sink_pkg;
  localparam logic [7:0] CTRL_HDR = 8'hFF;
  localparam logic [7:0] CTRL_DATA = 8'h00;
  localparam logic [12:0] WORDS_MAX = '1;
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;
  typedef enum logic [1:0] {BP_ALWAYS, BP_ALT, BP_LFSR, BP_NEVER} bp_mode_t;
  typedef enum logic [1:0] {CL_HDR, CL_DATA, CL_EOP, CL_ILL} ctrl_class_t;
  function automatic ctrl_class_t classify(input logic [7:0] c);
    return c == CTRL_HDR ? CL_HDR : c == CTRL_DATA ? CL_DATA :
           (c & (c - 8'd1)) == 8'd0 ? CL_EOP : CL_ILL;
  endfunction
  function automatic logic [3:0] eop_bytes(input logic [7:0] c);
    logic [3:0] k;
    k = '0;
    for (int i = 0; i < 8; i++) if (c[i]) k = 4'(8 - i);
    return k;
  endfunction
endpackage

// File: rtl/fifo_pkt_sink_bp_lfsr16.sv
// bp_lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); ports clk, reset, state
module bp_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);
  always_ff @(posedge clk)
    if (reset) state <= SEED;
    else state <= {state[0] ^ state[2] ^ state[3] ^ state[5], state[15:1]};
endmodule

// File: rtl/fifo_pkt_sink.sv
// fifo_pkt_sink: packet sink with backpressure, framing check, counters, last length/signature
module fifo_pkt_sink
  import fifo_pkt_sink_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  input  logic [1:0]            bp_mode,
  input  logic                  clear,
  output logic [31:0]           pkt_count,
  output logic [31:0]           word_count,
  output logic [15:0]           err_count,
  output logic [15:0]           last_len,
  output logic [DATA_WIDTH-1:0] last_sig,
  output logic                  pkt_done
);
  logic [15:0] lfsr;
  state_t state, state_n;
  bp_mode_t bm;
  ctrl_class_t cls;
  logic [12:0] words, words_n;
  logic [DATA_WIDTH-1:0] sig, sig_n, masked;
  logic [3:0] k;
  logic acc, err, done;
  bp_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .state(lfsr));
  assign bm = bp_mode_t'(bp_mode);
  always_comb begin
    acc = in_wr && in_rdy;
    cls = classify(in_ctrl);
    k = eop_bytes(in_ctrl);
    masked = in_data & ({DATA_WIDTH{1'b1}} << (8 * (8 - int'(k))));
    state_n = state;
    words_n = words;
    sig_n = sig;
    err = in_wr && !in_rdy;
    done = 1'b0;
    if (acc)
      case (state)
        IDLE:
          if (cls == CL_HDR) state_n = HDR;
          else err = 1'b1;
        HDR:
          case (cls)
            CL_HDR: state_n = HDR;
            CL_DATA: begin
              state_n = PAYLOAD;
              words_n = 13'd1;
              sig_n = in_data;
            end
            default: begin
              err = 1'b1;
              state_n = IDLE;
            end
          endcase
        PAYLOAD:
          case (cls)
            CL_DATA: begin
              words_n = words == WORDS_MAX ? words : words + 13'd1;
              sig_n = sig ^ in_data;
            end
            CL_EOP: begin
              done = 1'b1;
              state_n = IDLE;
            end
            default: begin
              err = 1'b1;
              state_n = IDLE;
            end
          endcase
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      words <= '0;
      sig <= '0;
      in_rdy <= 1'b0;
      pkt_count <= '0;
      word_count <= '0;
      err_count <= '0;
      last_len <= '0;
      last_sig <= '0;
      pkt_done <= 1'b0;
    end else begin
      state <= state_n;
      words <= words_n;
      sig <= sig_n;
      in_rdy <= bm == BP_ALWAYS || (bm == BP_ALT && !in_rdy) || (bm == BP_LFSR && (lfsr & 16'h0001) != 16'h0);
      pkt_done <= done;
      pkt_count <= clear ? '0 : pkt_count + 32'(done);
      word_count <= clear ? '0 : word_count + 32'(acc);
      err_count <= clear ? '0 : (err && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
      last_len <= done ? (words == WORDS_MAX ? 16'hFFFF : {words, 3'b000} + 16'(k)) : clear ? '0 : last_len;
      last_sig <= done ? sig ^ masked : clear ? '0 : last_sig;
    end
endmodule

// File: tb/tb_fifo_pkt_sink.sv
// tb_fifo_pkt_sink: directed plus randomized packet checks against a packet-level model
module tb_fifo_pkt_sink;
  logic clk = 0, reset = 1, in_wr = 0, clear = 0, in_rdy, pkt_done;
  logic [63:0] in_data = 0, last_sig;
  logic [7:0] in_ctrl = 0;
  logic [1:0] bp_mode = 0;
  logic [31:0] pkt_count, word_count;
  logic [15:0] err_count, last_len;
  int errors = 0, checks = 0, done_pulses = 0;
  fifo_pkt_sink dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy), .bp_mode(bp_mode), .clear(clear), .pkt_count(pkt_count),
    .word_count(word_count), .err_count(err_count), .last_len(last_len),
    .last_sig(last_sig), .pkt_done(pkt_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (pkt_done) done_pulses++;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] c, input logic [63:0] d);
    int g = 0;
    while (!in_rdy && g < 100) begin
      tick();
      g++;
    end
    if (g == 100) chk("rdy_timeout", in_rdy, 1);
    in_wr = 1;
    in_ctrl = c;
    in_data = d;
    tick();
    in_wr = 0;
  endtask
  task automatic do_clear;
    clear = 1;
    tick();
    clear = 0;
  endtask
  function automatic int valid_bytes(input logic [7:0] eop);
    for (int i = 0; i < 8; i++) if (eop == (8'h80 >> i)) return i + 1;
    return 0;
  endfunction
  function automatic logic [15:0] plen(input int nd, input logic [7:0] eop);
    int n = nd * 8 + valid_bytes(eop);
    return (nd >= 8191 || n > 65535) ? 16'hFFFF : 16'(n);
  endfunction
  function automatic logic [63:0] pmask(input logic [7:0] eop);
    logic [63:0] m = 0;
    for (int b = 0; b < valid_bytes(eop); b++) m[63 - 8*b -: 8] = 8'hFF;
    return m;
  endfunction
  task automatic rand_pkts(input string tag, input int n, inout int tw);
    for (int p = 0; p < n; p++) begin
      int nh = $urandom_range(1, 2);
      int nd = $urandom_range(1, 6);
      logic [7:0] eop = 8'h01 << $urandom_range(0, 7);
      logic [63:0] s = 0, d;
      for (int h = 0; h < nh; h++) send(8'hFF, {$urandom, $urandom});
      for (int i = 0; i < nd; i++) begin
        d = {$urandom, $urandom};
        s ^= d;
        send(8'h00, d);
      end
      d = {$urandom, $urandom};
      send(eop, d);
      tw += nh + nd + 1;
      chk({tag, "_len"}, last_len, plen(nd, eop));
      chk({tag, "_sig"}, last_sig, s ^ (d & pmask(eop)));
      chk({tag, "_done"}, pkt_done, 1);
    end
  endtask
  initial begin
    int tw;
    logic [15:0] m;
    logic [63:0] d;
    tick();
    tick();
    chk("rst_rdy", in_rdy, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_word", word_count, 0);
    chk("rst_err", err_count, 0);
    chk("rst_len", last_len, 0);
    chk("rst_sig", last_sig, 0);
    chk("rst_done", pkt_done, 0);
    reset = 0;
    tick();
    chk("rdy_rise", in_rdy, 1);
    send(8'hFF, 64'h0);
    send(8'h00, 64'h1111_1111_1111_1111);
    send(8'h01, 64'h2222_2222_2222_2222);
    chk("t1_pkt", pkt_count, 1);
    chk("t1_len", last_len, 16);
    chk("t1_sig", last_sig, 64'h3333_3333_3333_3333);
    chk("t1_word", word_count, 3);
    chk("t1_done", pkt_done, 1);
    tick();
    chk("t1_done_low", pkt_done, 0);
    chk("t1_pulses", done_pulses, 1);
    send(8'hFF, 64'h0);
    send(8'h00, 64'h0123_4567_89AB_CDEF);
    send(8'h80, 64'hAB00_0000_0000_00FF);
    chk("t2_len", last_len, 9);
    chk("t2_sig", last_sig, 64'h0123_4567_89AB_CDEF ^ 64'hAB00_0000_0000_0000);
    chk("t2_pkt", pkt_count, 2);
    do_clear();
    chk("clr_pkt", pkt_count, 0);
    chk("clr_word", word_count, 0);
    chk("clr_len", last_len, 0);
    chk("clr_sig", last_sig, 0);
    send(8'h00, 64'h5);
    chk("e_idle_data", err_count, 1);
    send(8'hFF, 64'h0);
    send(8'h04, 64'h6);
    chk("e_hdr_eop", err_count, 2);
    send(8'hFF, 64'h0);
    send(8'h00, 64'h7);
    send(8'h03, 64'h8);
    chk("e_illegal", err_count, 3);
    chk("e_pkt", pkt_count, 0);
    send(8'hFF, 64'h0);
    send(8'h00, 64'h9);
    send(8'h01, 64'hA);
    chk("e_recover_pkt", pkt_count, 1);
    chk("e_recover_len", last_len, 16);
    chk("e_word", word_count, 9);
    bp_mode = 3;
    tick();
    do_clear();
    in_wr = 1;
    tick();
    in_wr = 0;
    tick();
    in_wr = 1;
    tick();
    in_wr = 0;
    chk("ovr_err", err_count, 2);
    chk("ovr_word", word_count, 0);
    chk("ovr_rdy", in_rdy, 0);
    bp_mode = 1;
    tick();
    do_clear();
    tw = 0;
    rand_pkts("m1", 100, tw);
    chk("m1_pkt", pkt_count, 100);
    chk("m1_err", err_count, 0);
    chk("m1_word", word_count, tw);
    bp_mode = 2;
    reset = 1;
    tick();
    reset = 0;
    m = 16'hACE1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("lfsr_rdy", in_rdy, m[0]);
      m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
    end
    do_clear();
    tw = 0;
    rand_pkts("m2", 100, tw);
    chk("m2_pkt", pkt_count, 100);
    chk("m2_err", err_count, 0);
    chk("m2_word", word_count, tw);
    bp_mode = 0;
    tick();
    tick();
    send(8'hFF, 64'h0);
    send(8'h00, 64'h1);
    reset = 1;
    tick();
    reset = 0;
    tick();
    send(8'hFF, 64'h0);
    send(8'h00, 64'h4444);
    send(8'h10, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rm_err", err_count, 0);
    chk("rm_pkt", pkt_count, 1);
    chk("rm_len", last_len, plen(1, 8'h10));
    d = {$urandom, $urandom};
    send(8'hFF, 64'h0);
    send(8'h00, d);
    clear = 1;
    send(8'h02, 64'hDEAD_BEEF_CAFE_F00D);
    clear = 0;
    chk("ce_pkt", pkt_count, 0);
    chk("ce_word", word_count, 0);
    chk("ce_len", last_len, 15);
    chk("ce_sig", last_sig, d ^ 64'hDEAD_BEEF_CAFE_F000);
    chk("ce_done", pkt_done, 1);
    send(8'hFF, 64'h0);
    for (int i = 0; i < 8190; i++) send(8'h00, 64'h5);
    send(8'h01, 64'h0);
    chk("big_len", last_len, 16'hFFF8);
    send(8'hFF, 64'h0);
    for (int i = 0; i < 8191; i++) send(8'h00, 64'h5);
    send(8'h80, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sat_len", last_len, plen(8191, 8'h80));
    chk("sat_sig", last_sig, 64'hFF00_0000_0000_0005);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
